// File: rtl/noc_pkg.sv
// Shared NoC flit definitions: flit width, field offsets and flit-type encoding.
// Layout from MSB to LSB: valid, dest, src, data[16], instr[3], packet_id, flit_type[2].
package noc_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned INSTR_W = 3;
    localparam int unsigned TYPE_W  = 2;

    typedef enum logic [1:0] {
        FlitHead   = 2'd0,
        FlitBody   = 2'd1,
        FlitTail   = 2'd2,
        FlitSingle = 2'd3
    } flit_type_e;

    function automatic int unsigned flit_w(int unsigned nodes, int unsigned pid_w);
        return 1 + 2 * $clog2(nodes) + DATA_W + INSTR_W + pid_w + TYPE_W;
    endfunction

    function automatic int unsigned type_lsb();
        return 0;
    endfunction

    function automatic int unsigned pid_lsb();
        return TYPE_W;
    endfunction

    function automatic int unsigned instr_lsb(int unsigned pid_w);
        return TYPE_W + pid_w;
    endfunction

    function automatic int unsigned data_lsb(int unsigned pid_w);
        return TYPE_W + pid_w + INSTR_W;
    endfunction

    function automatic int unsigned src_lsb(int unsigned pid_w);
        return TYPE_W + pid_w + INSTR_W + DATA_W;
    endfunction

    function automatic int unsigned dest_lsb(int unsigned nodes, int unsigned pid_w);
        return src_lsb(pid_w) + $clog2(nodes);
    endfunction

    function automatic int unsigned valid_bit(int unsigned nodes, int unsigned pid_w);
        return flit_w(nodes, pid_w) - 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO: storage, wrapping pointers and fill level.
// The caller guarantees push only when not full and pop only when not empty.
module sync_fifo
    import noc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Pointers wrap naturally since DEPTH is a power of two; occupancy separates full from empty.
    always_comb begin
        wptr_d = wptr_q + PTR_W'(push);
        rptr_d = rptr_q + PTR_W'(pop);
        occ_d  = occ_q + OCC_W'(push) - OCC_W'(pop);
    end

    // Pointer and fill-level registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
        end
    end

    // Storage array is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    assign rdata     = mem_q[rptr_q];
    assign occupancy = occ_q;

endmodule

// File: rtl/flit_egress_buffer.sv
// Egress buffer between a tile and its router local port: flit FIFO plus credit-based
// flow control, registered flit output and sticky error flags.
module flit_egress_buffer
    import noc_pkg::*;
#(
    parameter int NODE_COUNT      = 16,
    parameter int PACKET_ID_WIDTH = 5,
    parameter int DEPTH           = 4,
    parameter int CREDITS         = 4,
    localparam int FLIT_W         = flit_w(NODE_COUNT, PACKET_ID_WIDTH),
    localparam int OCC_W          = $clog2(DEPTH) + 1,
    localparam int CRED_W         = $clog2(CREDITS) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] flit_in,
    output logic              network_ready,
    output logic [FLIT_W-1:0] flit_out,
    input  logic              credit_return,
    output logic [OCC_W-1:0]  occupancy,
    output logic [CRED_W-1:0] credits_avail,
    output logic              overflow_err,
    output logic              credit_err
);

    localparam int VALID_BIT = valid_bit(NODE_COUNT, PACKET_ID_WIDTH);

    logic              offered;
    logic              push;
    logic              pop;
    logic [FLIT_W-1:0] head;
    logic [OCC_W-1:0]  occ;
    logic              credits_full;

    logic [CRED_W-1:0] credit_q, credit_d;
    logic [FLIT_W-1:0] flit_out_q, flit_out_d;
    logic              ovf_q, ovf_d;
    logic              cerr_q, cerr_d;

    sync_fifo #(
        .WIDTH (FLIT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .wdata     (flit_in),
        .rdata     (head),
        .occupancy (occ)
    );

    // Ready depends only on registered fill level, never on this cycle's pop.
    assign network_ready = (occ < OCC_W'(DEPTH));

    // Next-state for credits, output register and error flags.
    always_comb begin
        offered      = flit_in[VALID_BIT];
        push         = offered && network_ready;
        pop          = (occ != '0) && (credit_q != '0);
        credits_full = (credit_q == CRED_W'(CREDITS));
        flit_out_d   = pop ? head : '0;
        credit_d     = credit_q;
        ovf_d        = ovf_q | (offered & ~network_ready);
        cerr_d       = cerr_q;
        if (pop && !credit_return) begin
            credit_d = credit_q - 1'b1;
        end else if (!pop && credit_return) begin
            if (credits_full) begin
                cerr_d = 1'b1;
            end else begin
                credit_d = credit_q + 1'b1;
            end
        end
    end

    // State registers; reset restores a full credit count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_q   <= CRED_W'(CREDITS);
            flit_out_q <= '0;
            ovf_q      <= 1'b0;
            cerr_q     <= 1'b0;
        end else begin
            credit_q   <= credit_d;
            flit_out_q <= flit_out_d;
            ovf_q      <= ovf_d;
            cerr_q     <= cerr_d;
        end
    end

    assign flit_out      = flit_out_q;
    assign occupancy     = occ;
    assign credits_avail = credit_q;
    assign overflow_err  = ovf_q;
    assign credit_err    = cerr_q;

endmodule

// File: tb/tb_flit_egress_buffer.sv
// Bench for flit_egress_buffer: three instances (CREDITS = 4, 2, 1) share one stimulus
// stream; a list-based model is checked every cycle, plus literal scenario checks.
module tb_flit_egress_buffer;

    localparam int FW = 35;
    localparam int D  = 4;
    localparam int NI = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [FW-1:0] flit_in = '0;
    logic          credit_return = 1'b0;

    logic [FW-1:0] fo   [NI];
    logic [2:0]    occ  [NI];
    logic [2:0]    ca   [NI];
    logic          rdy  [NI];
    logic          ovf  [NI];
    logic          cerr [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int CR = (g == 0) ? 4 : ((g == 1) ? 2 : 1);
        localparam int CW = $clog2(CR) + 1;
        logic [CW-1:0] ca_l;
        flit_egress_buffer #(
            .NODE_COUNT      (16),
            .PACKET_ID_WIDTH (5),
            .DEPTH           (D),
            .CREDITS         (CR)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .flit_in       (flit_in),
            .network_ready (rdy[g]),
            .flit_out      (fo[g]),
            .credit_return (credit_return),
            .occupancy     (occ[g]),
            .credits_avail (ca_l),
            .overflow_err  (ovf[g]),
            .credit_err    (cerr[g])
        );
        assign ca[g] = 3'(ca_l);
    end

    int n_checks = 0;
    int n_pass   = 0;
    bit started  = 1'b0;

    task automatic check(input string name, input int g, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s inst%0d: got 0x%0h, expected 0x%0h", name, g, act, exp);
    endtask

    function automatic int cr_of(input int g);
        return (g == 0) ? 4 : ((g == 1) ? 2 : 1);
    endfunction

    function automatic logic [FW-1:0] fl(input int i);
        logic [33:0] p;
        p = 34'h2_3456_7800 + 34'(i);
        return {1'b1, p};
    endfunction

    // Model: an ordered list of buffered flits and a credit count per instance.
    logic [FW-1:0] m_list [NI][D];
    int            m_cnt  [NI];
    int            m_cr   [NI];
    logic          m_ovf  [NI];
    logic          m_cerr [NI];
    logic [FW-1:0] m_out  [NI];

    task automatic model_step(input int g);
        bit pop;
        bit ready;
        if (rst) begin
            m_cnt[g] = 0; m_cr[g] = cr_of(g); m_ovf[g] = 0; m_cerr[g] = 0; m_out[g] = '0;
            return;
        end
        pop   = (m_cnt[g] > 0) && (m_cr[g] > 0);
        ready = (m_cnt[g] < D);
        m_out[g] = pop ? m_list[g][0] : '0;
        if (pop) begin
            for (int k = 0; k < D - 1; k++) m_list[g][k] = m_list[g][k+1];
            m_cnt[g]--;
        end
        if (flit_in[FW-1]) begin
            if (ready) begin
                m_list[g][m_cnt[g]] = flit_in;
                m_cnt[g]++;
            end else begin
                m_ovf[g] = 1'b1;
            end
        end
        if (pop && !credit_return) m_cr[g]--;
        else if (!pop && credit_return) begin
            if (m_cr[g] == cr_of(g)) m_cerr[g] = 1'b1;
            else m_cr[g]++;
        end
    endtask

    initial begin
        for (int g = 0; g < NI; g++) begin
            m_cnt[g] = 0; m_cr[g] = cr_of(g); m_ovf[g] = 0; m_cerr[g] = 0; m_out[g] = '0;
        end
        forever begin
            @(posedge clk or posedge rst);
            for (int g = 0; g < NI; g++) model_step(g);
        end
    end

    // Per-cycle comparison against the model, plus output-flit counting.
    int            out_cnt  [NI] = '{0, 0, 0};
    logic [FW-1:0] last_out [NI];

    always @(negedge clk) begin
        if (started) begin
            for (int g = 0; g < NI; g++) begin
                check("flit_out", g, 64'(fo[g]), 64'(m_out[g]));
                check("occupancy", g, 64'(occ[g]), 64'(m_cnt[g]));
                check("credits_avail", g, 64'(ca[g]), 64'(m_cr[g]));
                check("network_ready", g, 64'(rdy[g]), 64'(m_cnt[g] < D));
                check("overflow_err", g, 64'(ovf[g]), 64'(m_ovf[g]));
                check("credit_err", g, 64'(cerr[g]), 64'(m_cerr[g]));
                if (fo[g][FW-1]) begin
                    out_cnt[g]++;
                    last_out[g] = fo[g];
                end
            end
        end
    end

    // Inputs change 2 time units after the falling edge; literal checks happen there too.
    task automatic step(input logic [FW-1:0] f, input logic cr);
        flit_in = f;
        credit_return = cr;
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flit_in = '0;
        credit_return = 1'b0;
        @(negedge clk);
        #2;
        for (int g = 0; g < NI; g++) begin
            check("rst_flit_out", g, 64'(fo[g]), 64'd0);
            check("rst_occupancy", g, 64'(occ[g]), 64'd0);
            check("rst_credits", g, 64'(ca[g]), 64'(cr_of(g)));
            check("rst_errs", g, 64'({ovf[g], cerr[g]}), 64'd0);
        end
        rst = 1'b0;
        started = 1'b1;
        step('0, 1'b0);
    endtask

    localparam logic [FW-1:0] FA5 = {1'b1, 34'h0A5};

    initial begin
        int b;
        @(negedge clk);
        #2;

        // Single flit, two-cycle latency.
        do_reset();
        step(FA5, 1'b0);
        step('0, 1'b0);
        check("single_out_k2", 0, 64'(fo[0]), 64'(FA5));
        step('0, 1'b0);
        check("single_out_k3", 0, 64'(fo[0]), 64'd0);
        check("single_credits", 0, 64'(ca[0]), 64'd3);

        // Credit starvation on the CREDITS=2 instance.
        do_reset();
        b = out_cnt[1];
        for (int i = 0; i < 5; i++) begin
            step(fl(i), 1'b0);
            check("starve_ready", 1, 64'(rdy[1]), 64'd1);
        end
        step('0, 1'b0);
        check("starve_sent", 1, 64'(out_cnt[1] - b), 64'd2);
        check("starve_occ", 1, 64'(occ[1]), 64'd3);
        check("starve_last", 1, 64'(last_out[1]), 64'(fl(1)));
        step('0, 1'b1);
        step('0, 1'b0);
        check("starve_one_more", 1, 64'(out_cnt[1] - b), 64'd3);
        check("starve_order", 1, 64'(last_out[1]), 64'(fl(2)));
        check("starve_occ2", 1, 64'(occ[1]), 64'd2);

        // Full and overflow on the CREDITS=1 instance.
        do_reset();
        b = out_cnt[2];
        for (int i = 0; i < 6; i++) step(fl(10 + i), 1'b0);
        check("ovf_sent", 2, 64'(out_cnt[2] - b), 64'd1);
        check("ovf_occ", 2, 64'(occ[2]), 64'd4);
        check("ovf_ready", 2, 64'(rdy[2]), 64'd0);
        check("ovf_flag", 2, 64'(ovf[2]), 64'd1);
        check("ovf_flag_other", 1, 64'(ovf[1]), 64'd0);

        // Simultaneous pop and credit return at one credit.
        step('0, 1'b1);
        check("simul_pre_cred", 2, 64'(ca[2]), 64'd1);
        check("simul_pre_out", 2, 64'(fo[2]), 64'd0);
        step('0, 1'b1);
        check("simul_cred", 2, 64'(ca[2]), 64'd1);
        check("simul_out", 2, 64'(fo[2]), 64'(fl(11)));
        check("simul_occ", 2, 64'(occ[2]), 64'd3);

        // Credit return while already full of credits.
        do_reset();
        step('0, 1'b1);
        check("cerr_cred", 0, 64'(ca[0]), 64'd4);
        check("cerr_flag", 0, 64'(cerr[0]), 64'd1);
        step('0, 1'b0);
        check("cerr_sticky", 0, 64'(cerr[0]), 64'd1);

        // Reset mid-stream discards buffered flits.
        do_reset();
        for (int i = 0; i < 5; i++) step(fl(20 + i), 1'b0);
        check("mid_occ", 1, 64'(occ[1]), 64'd3);
        b = out_cnt[1];
        rst = 1'b1;
        @(negedge clk);
        #2;
        check("mid_rst_out", 1, 64'(fo[1]), 64'd0);
        check("mid_rst_occ", 1, 64'(occ[1]), 64'd0);
        check("mid_rst_cred", 1, 64'(ca[1]), 64'd2);
        check("mid_rst_errs", 1, 64'({ovf[1], cerr[1]}), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step('0, 1'b0);
        check("mid_no_emit", 1, 64'(out_cnt[1] - b), 64'd0);
        step(fl(30), 1'b0);
        step('0, 1'b0);
        check("mid_after_lat", 1, 64'(fo[1]), 64'(fl(30)));
        step('0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/flit_egress_buffer.md
FLIT_EGRESS_BUFFER -- requirements
Module: flit_egress_buffer

Interface
REQ-001 SHALL have parameter NODE_COUNT, default 16, number of NoC nodes.
REQ-002 SHALL have parameter PACKET_ID_WIDTH, default 5, packet-id field width.
REQ-003 SHALL have parameter DEPTH, default 4, flit FIFO entries (power of two, >=2).
REQ-004 SHALL have parameter CREDITS, default 4, router input-buffer credits (>=1).
REQ-005 SHALL derive FLIT_W = 1 + 2*$clog2(NODE_COUNT) + 16 + 3 + PACKET_ID_WIDTH + 2; the MSB is the flit-valid bit.
REQ-006 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port flit_in  input  FLIT_W  flit from the tile's splitter output; a flit is offered when the MSB is 1.
REQ-009 SHALL have port network_ready  output  1  back-pressure to the tile; high when the FIFO can accept a flit.
REQ-010 SHALL have port flit_out  output  FLIT_W  flit to the router local port; all-zero when idle.
REQ-011 SHALL have port credit_return  input  1  one-cycle pulse, returns one router credit.
REQ-012 SHALL have port occupancy  output  $clog2(DEPTH)+1  current FIFO fill level.
REQ-013 SHALL have port credits_avail  output  $clog2(CREDITS)+1  current credit count.
REQ-014 SHALL have port overflow_err  output  1  sticky flag: flit offered while full.
REQ-015 SHALL have port credit_err  output  1  sticky flag: credit returned while at CREDITS.

Function
REQ-016 SHALL drive network_ready = (occupancy < DEPTH), combinationally from registered state only.
REQ-017 SHALL push flit_in on the clock edge when flit_in MSB = 1 and network_ready = 1.
REQ-018 SHALL drop a flit offered while full and set overflow_err; a pop in the same cycle does not rescue it.
REQ-019 SHALL pop the head flit on the clock edge when occupancy > 0 and credits_avail > 0.
REQ-020 SHALL register flit_out: on a pop it SHALL load the head flit; otherwise it SHALL load all-zero. Valid is therefore one cycle per flit.
REQ-021 SHALL have a latency of 2 cycles: a flit offered in cycle k into an empty FIFO with credits > 0 appears on flit_out in cycle k+2.
REQ-022 SHALL sustain one flit per cycle when not credit-starved, with push and pop in the same cycle and occupancy unchanged.
REQ-023 SHALL emit flits in exact FIFO order, bit-identical to flit_in, with no field modified.
REQ-024 SHALL update the credit count as follows: decrement on pop, increment on credit_return, unchanged when both occur in the same cycle.
REQ-025 SHALL ignore credit_return when credits_avail = CREDITS with no pop in that cycle, and set credit_err.
REQ-026 SHALL stall pops while credits_avail = 0; the FIFO keeps filling until network_ready drops.
REQ-027 SHALL wrap the read and write pointers modulo DEPTH; full and empty are distinguished by occupancy.
REQ-028 SHALL keep overflow_err and credit_err set until reset.

Reset
REQ-029 SHALL, while rst = 1, asynchronously clear occupancy, the pointers, flit_out (all zero) and both error flags, and set credits_avail = CREDITS.
REQ-030 SHALL discard flits in flight when reset is asserted mid-operation; the first flit after reset deassertion follows REQ-021.
REQ-031 SHALL not require the FIFO storage array to be reset.

Structure
REQ-032 SHALL take FLIT_W, the field offsets (valid, dest, src, data[16], instr[3], packet_id, flit_type[2]) and the flit-type enum from shared package noc_pkg.
REQ-033 SHALL instantiate one sub-module, sync_fifo (parameters WIDTH, DEPTH), holding the storage, pointers and occupancy; the credit counter and output register SHALL live in flit_egress_buffer.

Verification
REQ-034 SHALL cover single flit: DEPTH=4, CREDITS=4, flit 0x…A5 with MSB=1 in cycle 0 -> flit_out equals it in cycle 2, zero in cycle 3, credits_avail=3.
REQ-035 SHALL cover credit starvation: CREDITS=2, 5 back-to-back flits, no credit_return -> 2 flits out, occupancy reaches 3, network_ready stays 1; one credit_return pulse -> exactly one more flit out.
REQ-036 SHALL cover full/overflow: CREDITS=1 with no returns, 6 flits offered -> 1 sent, 4 buffered, network_ready=0, sixth flit dropped, overflow_err=1.
REQ-037 SHALL cover a simultaneous pop and credit_return at credits_avail=1 -> credits_avail stays 1, flit emitted.
REQ-038 SHALL cover credit_err: credit_return at credits_avail=4 with no pop -> credits_avail stays 4, credit_err=1.
REQ-039 SHALL cover reset mid-stream: rst pulse with 3 flits buffered -> flit_out=0, occupancy=0, credits_avail=CREDITS, error flags 0, and no buffered flit ever emitted.
